// File: rtl/tour_cmd_sequencer_if.sv
// Bundles the script-load, playback-control, RemoteComm handshake and status
// signals of tour_cmd_sequencer. master = sequencer side, slave = environment side.
interface tour_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW:0]   num_cmds;
  logic          start;
  logic [15:0]   cmd;
  logic          snd_cmd;
  logic          cmd_snt;
  logic          resp_rdy;
  logic [7:0]    resp;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW-1:0] cmd_idx;

  modport master (
    input  wr_en, wr_addr, wr_data, num_cmds, start, cmd_snt, resp_rdy, resp,
    output cmd, snd_cmd, busy, done, err, err_code, cmd_idx
  );

  modport slave (
    output wr_en, wr_addr, wr_data, num_cmds, start, cmd_snt, resp_rdy, resp,
    input  cmd, snd_cmd, busy, done, err, err_code, cmd_idx
  );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// Plays a stored script of 16-bit KnightsTour commands to RemoteComm, one per ack.
// Optional macro SEQ_RETRY_EN: one retry of a command after its first timeout.
module tour_cmd_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter logic [23:0] RESP_TIMEOUT = 24'd8_000_000,
  parameter logic [7:0]  ACK          = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  tour_cmd_sequencer_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WAIT_SNT  = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_ERROR     = 3'd5;

  localparam logic [1:0] E_NAK = 2'b01;
  localparam logic [1:0] E_TMO = 2'b10;

`ifdef SEQ_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  logic [15:0]   r_mem [DEPTH];
  logic [2:0]    r_state;
  logic [15:0]   r_cmd;
  logic          r_snd;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_code;
  logic [AW-1:0] r_idx;
  logic [AW:0]   r_num;
  logic [23:0]   r_tmo;
  logic          r_retried;

  logic [AW:0]   w_num_clamped;
  logic          w_last;
  logic [23:0]   w_tmo_next;
  logic          w_timeout;

  always_comb begin
    w_num_clamped = (bus.num_cmds > DEPTH_W) ? DEPTH_W : bus.num_cmds;
    w_last        = ({1'b0, r_idx} == (r_num - 1'b1));
    w_tmo_next    = r_tmo + 24'd1;
    // A response (or cmd_snt) on the same clock as the timeout takes precedence.
    w_timeout     = (w_tmo_next == RESP_TIMEOUT) &&
                    (((r_state == S_WAIT_SNT)  && !bus.cmd_snt) ||
                     ((r_state == S_WAIT_RESP) && !bus.resp_rdy));
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && !r_busy) r_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cmd     <= '0;
      r_snd     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= '0;
      r_idx     <= '0;
      r_num     <= '0;
      r_tmo     <= '0;
      r_retried <= 1'b0;
    end else begin
      r_snd <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= '0;
            r_idx     <= '0;
            r_num     <= w_num_clamped;
            r_retried <= 1'b0;
            if (w_num_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SEND;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SEND: begin
          r_cmd   <= r_mem[r_idx];
          r_snd   <= 1'b1;
          r_tmo   <= '0;
          r_state <= S_WAIT_SNT;
        end
        S_WAIT_SNT: begin
          r_tmo <= w_tmo_next;
          if (bus.cmd_snt) r_state <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          r_tmo <= w_tmo_next;
          if (bus.resp_rdy) begin
            if (bus.resp == ACK) begin
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_idx     <= r_idx + 1'b1;
                r_retried <= 1'b0;
                r_state   <= S_SEND;
              end
            end else begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
              r_code  <= E_NAK;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        if (RETRY_EN && !r_retried) begin
          r_retried <= 1'b1;
          r_state   <= S_SEND;
        end else begin
          r_state <= S_ERROR;
          r_err   <= 1'b1;
          r_code  <= E_TMO;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign bus.cmd      = r_cmd;
  assign bus.snd_cmd  = r_snd;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.err_code = r_code;
  assign bus.cmd_idx  = r_idx;
endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer: playback, NAK, timeout (with or without
// SEQ_RETRY_EN), spurious response, busy write, zero-length start and reset.
module tb_tour_cmd_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tour_cmd_sequencer_if #(.DEPTH(16)) bus();

  tour_cmd_sequencer #(
    .DEPTH(16),
    .RESP_TIMEOUT(24'd100),
    .ACK(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks    = 0;
  int failures  = 0;
  int snd_count = 0;

  always @(negedge clk) if (bus.snd_cmd === 1'b1) snd_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.num_cmds = '0;
    bus.start    = 1'b0;
    bus.cmd_snt  = 1'b0;
    bus.resp_rdy = 1'b0;
    bus.resp     = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick;
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] n);
    bus.num_cmds = n; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  task automatic wait_snd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.snd_cmd === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic send_resp(input logic [7:0] r);
    bus.cmd_snt = 1'b1;
    tick;
    bus.cmd_snt = 1'b0; bus.resp_rdy = 1'b1; bus.resp = r;
    tick;
    bus.resp_rdy = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    checks++;
    if (bus.cmd !== 16'h0 || bus.snd_cmd !== 1'b0 || bus.cmd_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_cmd: cmd=%h snd=%b idx=%0d, want 0000 0 0", bus.cmd, bus.snd_cmd, bus.cmd_idx);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 2'b00) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b err=%b code=%b, want 0 0 0 00",
               bus.busy, bus.done, bus.err, bus.err_code);
    end
  endtask

  task automatic test_playback;
    logic [15:0] exp_cmd [3];
    int base;
    bit ok;
    exp_cmd[0] = 16'hA000; exp_cmd[1] = 16'h4002; exp_cmd[2] = 16'h5BF1;
    for (int i = 0; i < 3; i++) wr(4'(i), exp_cmd[i]);
    base = snd_count;
    pulse_start(5'd3);
    checks++;
    if (bus.busy !== 1'b1 || bus.snd_cmd !== 1'b0) begin
      failures++;
      $display("FAIL start_edge1: busy=%b snd=%b, want 1 0", bus.busy, bus.snd_cmd);
    end
    tick;
    checks++;
    if (bus.snd_cmd !== 1'b1 || bus.cmd !== 16'hA000) begin
      failures++;
      $display("FAIL start_edge2: snd=%b cmd=%h, want 1 a000", bus.snd_cmd, bus.cmd);
    end
    for (int i = 0; i < 3; i++) begin
      wait_snd(ok);
      checks++;
      if (!ok || bus.cmd !== exp_cmd[i] || bus.cmd_idx !== 4'(i)) begin
        failures++;
        $display("FAIL play_cmd%0d: seen=%b cmd=%h idx=%0d, want 1 %h %0d",
                 i, ok, bus.cmd, bus.cmd_idx, exp_cmd[i], i);
      end
      send_resp(8'hA5);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.cmd_idx !== 4'd2) begin
      failures++;
      $display("FAIL play_done: done=%b busy=%b err=%b idx=%0d, want 1 0 0 2",
               bus.done, bus.busy, bus.err, bus.cmd_idx);
    end
    repeat (3) tick;
    checks++;
    if (snd_count - base !== 3) begin
      failures++;
      $display("FAIL play_pulses: snd_cmd pulses=%0d, want 3", snd_count - base);
    end
  endtask

  task automatic test_nak;
    int base;
    bit ok;
    wr(4'd0, 16'h1111);
    wr(4'd1, 16'h2222);
    base = snd_count;
    pulse_start(5'd2);
    wait_snd(ok);
    send_resp(8'hA5);
    wait_snd(ok);
    checks++;
    if (!ok || bus.cmd !== 16'h2222) begin
      failures++;
      $display("FAIL nak_second_cmd: seen=%b cmd=%h, want 1 2222", ok, bus.cmd);
    end
    send_resp(8'h5A);
    checks++;
    if (bus.err !== 1'b1 || bus.err_code !== 2'b01 || bus.cmd_idx !== 4'd1 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL nak_status: err=%b code=%b idx=%0d busy=%b done=%b, want 1 01 1 0 0",
               bus.err, bus.err_code, bus.cmd_idx, bus.busy, bus.done);
    end
    repeat (10) tick;
    checks++;
    if (snd_count - base !== 2 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL nak_halt: pulses=%0d err=%b, want 2 1", snd_count - base, bus.err);
    end
  endtask

  task automatic test_timeout;
    int base;
    bit ok;
    wr(4'd0, 16'hC0DE);
    base = snd_count;
    pulse_start(5'd1);
    wait_snd(ok);
    bus.cmd_snt = 1'b1;
    tick;
    bus.cmd_snt = 1'b0;
    repeat (98) tick;
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL tmo_early: err=%b busy=%b at 99 clks, want 0 1", bus.err, bus.busy);
    end
    tick;
`ifdef SEQ_RETRY_EN
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL tmo_retry_noerr: err=%b busy=%b at 100 clks, want 0 1", bus.err, bus.busy);
    end
    tick;
    checks++;
    if (bus.snd_cmd !== 1'b1 || bus.cmd !== 16'hC0DE || bus.cmd_idx !== 4'd0) begin
      failures++;
      $display("FAIL tmo_retry_snd: snd=%b cmd=%h idx=%0d, want 1 c0de 0",
               bus.snd_cmd, bus.cmd, bus.cmd_idx);
    end
    repeat (99) tick;
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_retry_early: err=%b at 99 clks, want 0", bus.err);
    end
    tick;
`endif
    checks++;
    if (bus.err !== 1'b1 || bus.err_code !== 2'b10 || bus.cmd_idx !== 4'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_error: err=%b code=%b idx=%0d busy=%b, want 1 10 0 0",
               bus.err, bus.err_code, bus.cmd_idx, bus.busy);
    end
    checks++;
`ifdef SEQ_RETRY_EN
    if (snd_count - base !== 2) begin
      failures++;
      $display("FAIL tmo_pulses: pulses=%0d, want 2", snd_count - base);
    end
`else
    if (snd_count - base !== 1) begin
      failures++;
      $display("FAIL tmo_pulses: pulses=%0d, want 1", snd_count - base);
    end
`endif
  endtask

  task automatic test_spurious;
    int base;
    bit ok;
    wr(4'd0, 16'h1357);
    wr(4'd1, 16'h2468);
    base = snd_count;
    pulse_start(5'd2);
    wait_snd(ok);
    bus.resp_rdy = 1'b1; bus.resp = 8'hA5;
    tick;
    bus.resp_rdy = 1'b0;
    repeat (3) tick;
    checks++;
    if (bus.cmd_idx !== 4'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0 || snd_count - base !== 1) begin
      failures++;
      $display("FAIL spur_ignored: idx=%0d busy=%b done=%b pulses=%0d, want 0 1 0 1",
               bus.cmd_idx, bus.busy, bus.done, snd_count - base);
    end
    send_resp(8'hA5);
    wait_snd(ok);
    checks++;
    if (!ok || bus.cmd_idx !== 4'd1 || bus.cmd !== 16'h2468) begin
      failures++;
      $display("FAIL spur_advance: seen=%b idx=%0d cmd=%h, want 1 1 2468", ok, bus.cmd_idx, bus.cmd);
    end
    send_resp(8'hA5);
    checks++;
    if (bus.done !== 1'b1 || snd_count - base !== 2) begin
      failures++;
      $display("FAIL spur_done: done=%b pulses=%0d, want 1 2", bus.done, snd_count - base);
    end
  endtask

  task automatic test_busy_zero_rst;
    int base;
    bit ok;
    wr(4'd0, 16'hBEEF);
    pulse_start(5'd1);
    wait_snd(ok);
    wr(4'd0, 16'h1234);
    bus.cmd_snt = 1'b1;
    tick;
    bus.cmd_snt = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (bus.cmd !== 16'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.err_code !== 2'b00 || bus.cmd_idx !== 4'd0 || bus.snd_cmd !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: cmd=%h busy=%b done=%b err=%b code=%b idx=%0d snd=%b, want all 0",
               bus.cmd, bus.busy, bus.done, bus.err, bus.err_code, bus.cmd_idx, bus.snd_cmd);
    end
    base = snd_count;
    pulse_start(5'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b busy=%b, want 1 0", bus.done, bus.busy);
    end
    repeat (4) tick;
    checks++;
    if (snd_count - base !== 0) begin
      failures++;
      $display("FAIL zero_nosnd: pulses=%0d, want 0", snd_count - base);
    end
    pulse_start(5'd1);
    wait_snd(ok);
    checks++;
    if (!ok || bus.cmd !== 16'hBEEF) begin
      failures++;
      $display("FAIL script_intact: seen=%b cmd=%h, want 1 beef", ok, bus.cmd);
    end
    send_resp(8'hA5);
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL after_rst_done: done=%b err=%b, want 1 0", bus.done, bus.err);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs;
    test_reset;
    test_playback;
    test_nak;
    test_timeout;
    test_spurious;
    test_busy_zero_rst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
